// File: rtl/regfile_8x64_pkg.sv
// Shared datapath widths for the integer pipeline: register file geometry and
// the pipeline-register fields that carry register addresses and data.
package regfile_8x64_pkg;

    localparam int unsigned RF_DATA_W = 64;
    localparam int unsigned RF_ADDR_W = 3;
    localparam int unsigned RF_DEPTH  = 2 ** RF_ADDR_W;

    // Pipeline-register field widths that carry register-file values
    localparam int unsigned PIPE_DEST_W = RF_ADDR_W;
    localparam int unsigned PIPE_SRC_W  = RF_ADDR_W;
    localparam int unsigned PIPE_DATA_W = RF_DATA_W;

    typedef struct packed {
        logic                   en;
        logic [PIPE_DEST_W-1:0] addr;
        logic [PIPE_DATA_W-1:0] data;
    } wb_bus_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-writer bits and the RAW hazard flag for the two read ports.
module regfile_scoreboard
    import regfile_8x64_pkg::*;
#(
    parameter int unsigned ADDR_W  = RF_ADDR_W,
    parameter bit          ZERO_R0 = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              iss_en,
    input  logic [ADDR_W-1:0] iss_addr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr0,
    input  logic [ADDR_W-1:0] rd_addr1,
    output logic              hazard
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DEPTH-1:0] pend;
    logic [DEPTH-1:0] pend_nxt;
    logic [DEPTH-1:0] set_vec;
    logic [DEPTH-1:0] clr_vec;
    logic             haz0;
    logic             haz1;

    // Set beats clear so a newer issue to the same register stays outstanding
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (iss_en) set_vec = DEPTH'(1) << iss_addr;
        if (wr_en)  clr_vec = DEPTH'(1) << wr_addr;
        if (ZERO_R0) set_vec[0] = 1'b0;
        pend_nxt = (pend & ~clr_vec) | set_vec;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pend <= '0;
        else        pend <= pend_nxt;
    end

    // A same-cycle writeback resolves the hazard; the read takes the bypass
    always_comb begin
        haz0   = pend[rd_addr0] && !(wr_en && (wr_addr == rd_addr0));
        haz1   = pend[rd_addr1] && !(wr_en && (wr_addr == rd_addr1));
        hazard = rd_en && (haz0 || haz1);
    end

endmodule

// File: rtl/regfile_8x64.sv
// Two-read/one-write flop-based register file with write-through bypass,
// registered read ports, and a pending-writer scoreboard.
module regfile_8x64
    import regfile_8x64_pkg::*;
#(
    parameter int unsigned DATA_W  = RF_DATA_W,
    parameter int unsigned ADDR_W  = RF_ADDR_W,
    parameter bit          ZERO_R0 = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr0,
    input  logic [ADDR_W-1:0] rd_addr1,
    output logic [DATA_W-1:0] rd_data0,
    output logic [DATA_W-1:0] rd_data1,
    output logic              rd_valid,
    input  logic              iss_en,
    input  logic [ADDR_W-1:0] iss_addr,
    output logic              hazard
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_nxt0;
    logic [DATA_W-1:0] rd_nxt1;
    logic              wr_ok;

    assign wr_ok = wr_en && !(ZERO_R0 && (wr_addr == '0));

    // Storage is cleared by reset, so it must stay a flop array
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read mux with write-through bypass; r0 forced to zero when hardwired
    always_comb begin
        rd_nxt0 = mem[rd_addr0];
        rd_nxt1 = mem[rd_addr1];
        if (wr_ok && (wr_addr == rd_addr0)) rd_nxt0 = wr_data;
        if (wr_ok && (wr_addr == rd_addr1)) rd_nxt1 = wr_data;
        if (ZERO_R0 && (rd_addr0 == '0)) rd_nxt0 = '0;
        if (ZERO_R0 && (rd_addr1 == '0)) rd_nxt1 = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data0 <= '0;
            rd_data1 <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data0 <= rd_nxt0;
                rd_data1 <= rd_nxt1;
            end
        end
    end

    regfile_scoreboard #(
        .ADDR_W  (ADDR_W),
        .ZERO_R0 (ZERO_R0)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .rd_en    (rd_en),
        .rd_addr0 (rd_addr0),
        .rd_addr1 (rd_addr1),
        .hazard   (hazard)
    );

endmodule

// File: doc/regfile_8x64.md
REGFILE_8X64 -- requirements
Module: regfile_8x64

Interface
REQ-001 Parameter DATA_W, default 64, register data width.
REQ-002 Parameter ADDR_W, default 3, register address width; DEPTH = 2**ADDR_W = 8.
REQ-003 Parameter ZERO_R0, default 1; when 1, register 0 reads as zero and ignores writes.
REQ-004 clk  input  1  single clock, all state updates on posedge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 wr_en  input  1  writeback strobe from the end-of-pipe destination-address register.
REQ-007 wr_addr  input  ADDR_W  writeback destination register.
REQ-008 wr_data  input  DATA_W  writeback data.
REQ-009 rd_en  input  1  read request for both ports this cycle.
REQ-010 rd_addr0, rd_addr1  input  ADDR_W each  read addresses.
REQ-011 rd_data0, rd_data1  output  DATA_W each  registered read data.
REQ-012 rd_valid  output  1  one-cycle pulse marking rd_data0/1 updated.
REQ-013 iss_en  input  1  decode stage issues an instruction that will write iss_addr.
REQ-014 iss_addr  input  ADDR_W  destination of the issued instruction.
REQ-015 hazard  output  1  combinational RAW indication for current rd_addr0/1.

Function
REQ-016 Write: on posedge with wr_en=1, mem[wr_addr] <= wr_data; wr_addr=0 discarded when ZERO_R0=1.
REQ-017 Read latency: exactly 1 cycle; rd_en sampled at edge N -> rd_data0/1 and rd_valid=1 after edge N; rd_valid=0 after any edge with rd_en=0.
REQ-018 rd_data0/1 hold their value when rd_en=0.
REQ-019 Write-through bypass: rd_en and wr_en at the same edge with rd_addrX == wr_addr -> rd_dataX = wr_data (new value), except address 0 when ZERO_R0=1 -> zero.
REQ-020 Both read ports may address the same register; both return identical data.
REQ-021 Scoreboard: one pending bit per register, pend[DEPTH-1:0].
REQ-022 iss_en=1 at edge sets pend[iss_addr]; wr_en=1 at edge clears pend[wr_addr].
REQ-023 Simultaneous iss_en and wr_en to the same address: set wins (newer writer outstanding).
REQ-024 pend[0] never set when ZERO_R0=1.
REQ-025 hazard = rd_en AND ((pend[rd_addr0] AND NOT (wr_en AND wr_addr==rd_addr0)) OR same for rd_addr1).
REQ-026 A read whose hazard is cleared by a same-cycle writeback is served via REQ-019 bypass.
REQ-027 The block does not stall reads itself; the consumer gates rd_en on hazard.

Reset
REQ-028 rst_n=0 asynchronously clears all mem entries, pend, rd_data0/1, and rd_valid to 0.
REQ-029 Writes, issues, and reads presented while rst_n=0 are ignored.
REQ-030 First edge after rst_n deasserts operates normally; no recovery cycles.

Structure
REQ-031 DATA_W, ADDR_W, and the DEPTH derivation are placed in the shared datapath package alongside the pipeline-register widths.
REQ-032 One sub-module, regfile_scoreboard, holds pend and computes hazard; storage and read ports stay in the top module.
REQ-033 Storage is a flop array; no vendor RAM inference, because reset clears contents.

Verification
REQ-034 Reset then read r1..r7 -> all rd_data=0, rd_valid pulses one cycle after each rd_en.
REQ-035 Write r5=0xDEADBEEF_00000005, next cycle read rd_addr0=5, rd_addr1=5 -> both 0xDEADBEEF_00000005 one cycle later.
REQ-036 Same edge: wr r3=0x33, rd_addr0=3 -> rd_data0=0x33 (bypass); write r0=0xFF, read r0 -> 0.
REQ-037 iss r4, then rd_addr1=4 -> hazard=1; same cycle wr r4 -> hazard=0 and rd_data1=wr_data; iss r4 and wr r4 together -> pend[4] stays 1.
REQ-038 rst_n pulsed low mid-cycle after writes/issues -> rd_data, rd_valid, pend clear immediately without a clock edge; subsequent read of r5 returns 0.
